zc_spi_master: RTL and testbench

- SPI initiator (Z-controller style) that drives the SD-SPI bus: spi_sck, spi_mosi and spi_cs_n out, spi_miso in.
- Sits between the TSConf port-decode logic and the SD mux. Its far end is either the emulated sd_card responder or the physical SD_* pins.
- Shifts one byte per request, full duplex, SPI mode 0, MSB first.
- Chip-select is a software-written register; it is never toggled automatically.

---
 rtl/zc_spi_pkg.sv | 15 +
 rtl/zc_spi_act.sv | 49 ++++
 rtl/zc_spi_master.sv | 167 ++++++++++++++++
 tb/tb_zc_spi_master.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zc_spi_pkg.sv
// Shared types and constants for the zc_spi_master SPI initiator.
package zc_spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCK_LO = 2'd1,
      SCK_HI = 2'd2,
      FINISH = 2'd3
   } zc_spi_state_t;

   localparam logic            SPI_IDLE_MOSI = 1'b1;
   localparam logic [7:0]      SPI_RX_RESET  = 8'hFF;
   localparam int unsigned     SPI_BITS      = 8;

endpackage : zc_spi_pkg

// File: rtl/zc_spi_act.sv
// SD activity stretcher: sd_act stays high for ACT_TIMEOUT cycles after the
// last change seen on spi_mosi or spi_miso. Built only with ZC_SPI_ACT_EN.
module zc_spi_act
   import zc_spi_pkg::*;
#(
   parameter int unsigned ACT_TIMEOUT = 1000000
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic spi_mosi,
   input  logic spi_miso,
   output logic sd_act
);

   localparam int unsigned CNT_W = $clog2(ACT_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prev_mosi_q, prev_miso_q;
   logic             sd_act_q, sd_act_d;

   // Restart the stretch on any line change, otherwise count up to the limit.
   always_comb begin
      cnt_d = cnt_q;
      if ((spi_mosi != prev_mosi_q) || (spi_miso != prev_miso_q)) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_W'(ACT_TIMEOUT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      sd_act_d = (cnt_d < CNT_W'(ACT_TIMEOUT));
   end

   // Counter, indicator and previous-value registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= CNT_W'(ACT_TIMEOUT);
         sd_act_q    <= 1'b0;
         prev_mosi_q <= SPI_IDLE_MOSI;
         prev_miso_q <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         sd_act_q    <= sd_act_d;
         prev_mosi_q <= spi_mosi;
         prev_miso_q <= spi_miso;
      end
   end

   assign sd_act = sd_act_q;

endmodule : zc_spi_act

// File: rtl/zc_spi_master.sv
// Z-controller style SPI initiator: one byte per tx_start, mode 0, MSB first,
// software-owned chip select. Define ZC_SPI_ACT_EN to add the sd_act output.
module zc_spi_master
   import zc_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned ACT_TIMEOUT = 1000000
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                tx_start,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic                cs_wr,
   input  logic                cs_val,
   output logic                busy,
   output logic                done,
   output logic [SPI_BITS-1:0] rx_data,
   output logic                spi_sck,
   output logic                spi_mosi,
   input  logic                spi_miso,
`ifdef ZC_SPI_ACT_EN
   output logic                spi_cs_n,
   output logic                sd_act
`else
   output logic                spi_cs_n
`endif
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
   localparam int unsigned BIT_W = $clog2(SPI_BITS);

   // Reject unusable configurations at elaboration.
   if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_clk_div
      $error("zc_spi_master: CLK_DIV must be in 1..255");
   end
   if (ACT_TIMEOUT < 1) begin : g_bad_act_timeout
      $error("zc_spi_master: ACT_TIMEOUT must be at least 1");
   end

   zc_spi_state_t       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [SPI_BITS-1:0] sr_q, sr_d;
   logic [SPI_BITS-1:0] rx_q, rx_d;
   logic                rx_bit_q, rx_bit_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic                cs_q, cs_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                half_done;

   assign half_done = (cnt_q == CNT_W'(CLK_DIV - 1));

   // Next-state and output decode; miso is held on the rising edge and
   // shifted in on the falling edge so untransmitted bits are not overwritten.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sr_d     = sr_q;
      rx_d     = rx_q;
      rx_bit_d = rx_bit_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cs_d     = cs_wr ? cs_val : cs_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (tx_start) begin
               sr_d    = tx_data;
               bit_d   = '0;
               busy_d  = 1'b1;
               sck_d   = 1'b0;
               mosi_d  = tx_data[SPI_BITS-1];
               state_d = SCK_LO;
            end
         end
         SCK_LO: begin
            if (half_done) begin
               cnt_d    = '0;
               sck_d    = 1'b1;
               rx_bit_d = spi_miso;
               state_d  = SCK_HI;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SCK_HI: begin
            if (half_done) begin
               cnt_d = '0;
               sck_d = 1'b0;
               sr_d  = {sr_q[SPI_BITS-2:0], rx_bit_q};
               bit_d = bit_q + BIT_W'(1);
               if (bit_q == BIT_W'(SPI_BITS - 1)) begin
                  busy_d  = 1'b0;
                  mosi_d  = SPI_IDLE_MOSI;
                  state_d = FINISH;
               end else begin
                  mosi_d  = sr_q[SPI_BITS-2];
                  state_d = SCK_LO;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FINISH: begin
            rx_d    = sr_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         sr_q     <= '0;
         rx_q     <= SPI_RX_RESET;
         rx_bit_q <= 1'b0;
         sck_q    <= 1'b0;
         mosi_q   <= SPI_IDLE_MOSI;
         cs_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         sr_q     <= sr_d;
         rx_q     <= rx_d;
         rx_bit_q <= rx_bit_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         cs_q     <= cs_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rx_data  = rx_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_q;

`ifdef ZC_SPI_ACT_EN
   zc_spi_act #(
      .ACT_TIMEOUT(ACT_TIMEOUT)
   ) u_act (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .spi_mosi (mosi_q),
      .spi_miso (spi_miso),
      .sd_act   (sd_act)
   );
`endif

endmodule : zc_spi_master

// File: tb/tb_zc_spi_master.sv
// Self-checking bench for zc_spi_master (CLK_DIV=2, ACT_TIMEOUT=10).
module tb_zc_spi_master;

   localparam int unsigned D    = 2;
   localparam int unsigned XFER = 16 * D;

   logic       clk_sys  = 1'b0;
   logic       reset_n  = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       cs_wr    = 1'b0;
   logic       cs_val   = 1'b1;
   logic       spi_miso;
   logic       busy, done, spi_sck, spi_mosi, spi_cs_n;
   logic [7:0] rx_data;
`ifdef ZC_SPI_ACT_EN
   logic       sd_act;
`endif

   // miso source: 0 = loopback of mosi, 1 = tied high, 2 = responder byte
   int         mode     = 0;
   logic [7:0] resp     = 8'h00;
   int         ridx     = 0;
   logic       resp_bit = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   // activity monitors
   int   n_rise = 0, n_busy = 0, n_done = 0, n_fall = 0;
   logic prev_busy = 1'b0;

   // behavioural model
   bit         m_active = 1'b0;
   int         m_k      = 0;
   logic [7:0] m_tx     = 8'h00;
   logic [7:0] m_pend   = 8'h00;
   logic [7:0] m_rx     = 8'hFF;
   bit         m_done   = 1'b0;
   logic       m_cs     = 1'b1;

   assign spi_miso = (mode == 0) ? spi_mosi : (mode == 1) ? 1'b1 : resp_bit;

   zc_spi_master #(
      .CLK_DIV     (D),
      .ACT_TIMEOUT (10)
   ) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .cs_wr    (cs_wr),
      .cs_val   (cs_val),
      .busy     (busy),
      .done     (done),
      .rx_data  (rx_data),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
`ifdef ZC_SPI_ACT_EN
      .spi_cs_n (spi_cs_n),
      .sd_act   (sd_act)
`else
      .spi_cs_n (spi_cs_n)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Responder shifts its next bit out on every SCK falling edge.
   initial forever begin
      @(negedge spi_sck);
      ridx++;
      if (ridx < 8) resp_bit = resp[7 - ridx];
   end

   // Monitors for edge/pulse counts.
   initial forever begin
      @(posedge spi_sck);
      n_rise++;
   end
   initial forever begin
      @(negedge clk_sys);
      if (busy) n_busy++;
      if (done) n_done++;
      if (prev_busy && !busy) n_fall++;
      prev_busy = busy;
   end

   // Model: a transfer is a count of clk edges since the start was accepted.
   initial forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
         m_active = 1'b0;
         m_k      = 0;
         m_rx     = 8'hFF;
         m_done   = 1'b0;
         m_cs     = 1'b1;
      end else begin
         m_done = 1'b0;
         if (cs_wr) m_cs = cs_val;
         if (m_active) begin
            m_k++;
            if (m_k == XFER + 1) begin
               m_active = 1'b0;
               m_rx     = m_pend;
               m_done   = 1'b1;
            end
         end else if (tx_start) begin
            m_active = 1'b1;
            m_k      = 0;
            m_tx     = tx_data;
            m_pend   = (mode == 0) ? tx_data : (mode == 1) ? 8'hFF : resp;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      logic e_busy, e_sck, e_mosi;
      @(negedge clk_sys);
      e_busy = 1'b0;
      e_sck  = 1'b0;
      e_mosi = 1'b1;
      if (m_active && (m_k < XFER)) begin
         e_busy = 1'b1;
         e_sck  = ((m_k / D) % 2) == 1;
         e_mosi = m_tx[7 - (m_k / (2 * D))];
      end
      chk("busy", int'(busy), int'(e_busy));
      chk("spi_sck", int'(spi_sck), int'(e_sck));
      chk("spi_mosi", int'(spi_mosi), int'(e_mosi));
      chk("spi_cs_n", int'(spi_cs_n), int'(m_cs));
      chk("done", int'(done), int'(m_done));
      chk("rx_data", int'(rx_data), int'(m_rx));
   end

   task automatic clr_counts();
      n_rise = 0;
      n_busy = 0;
      n_done = 0;
      n_fall = 0;
   endtask

   task automatic start(input logic [7:0] b);
      @(posedge clk_sys);
      #1;
      tx_start = 1'b1;
      tx_data  = b;
      @(posedge clk_sys);
      #1;
      tx_start = 1'b0;
   endtask

   // Returns edges from the accepting edge to the edge that raises done.
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk_sys);
         lat++;
         @(negedge clk_sys);
         if (done) break;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_done: no done pulse within %0d cycles", lat);
      end
   endtask

   initial begin
      int lat;
      int hi;

      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int hi;

      // Reset values
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sck", int'(spi_sck), 0);
      chk("rst_mosi", int'(spi_mosi), 1);
      chk("rst_cs", int'(spi_cs_n), 1);
      chk("rst_rx", int'(rx_data), 8'hFF);
      @(posedge clk_sys);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);

      // 1: loopback A5
      mode = 0;
      clr_counts();
      start(8'hA5);
      wait_done(lat);
      chk("t1_latency", lat, 33);
      chk("t1_rx", int'(rx_data), 8'hA5);
      repeat (2) @(posedge clk_sys);
      #1;
      chk("t1_sck_rises", n_rise, 8);
      chk("t1_busy_cycles", n_busy, 32);
      chk("t1_done_count", n_done, 1);

      // 2: miso high, send 00
      mode = 1;
      clr_counts();
      start(8'h00);
      wait_done(lat);
      chk("t2_rx", int'(rx_data), 8'hFF);
      chk("t2_mosi_idle", int'(spi_mosi), 1);
`ifdef ZC_SPI_ACT_EN
      chk("t2_act_at_done", int'(sd_act), 1);
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_sys);
         if (sd_act) hi++;
         else break;
      end
      chk("t2_act_stretch", hi, 9);
      chk("t2_act_off", int'(sd_act), 0);
`endif
      repeat (2) @(posedge clk_sys);

      // 3: responder returns 3C
      mode     = 2;
      resp     = 8'h3C;
      ridx     = 0;
      resp_bit = resp[7];
      clr_counts();
      start(8'hC3);
      wait_done(lat);
      chk("t3_rx", int'(rx_data), 8'h3C);
      repeat (2) @(posedge clk_sys);

      // 4: second start while busy is dropped
      mode = 0;
      clr_counts();
      start(8'h22);
      repeat (4) @(posedge clk_sys);
      #1;
      tx_start = 1'b1;
      tx_data  = 8'h11;
      @(posedge clk_sys);
      #1 tx_start = 1'b0;
      wait_done(lat);
      chk("t4_rx", int'(rx_data), 8'h22);
      repeat (40) @(posedge clk_sys);
      #1;
      chk("t4_done_count", n_done, 1);
      chk("t4_busy_falls", n_fall, 1);

      // 5: CS with start, then CS release mid-transfer
      clr_counts();
      @(posedge clk_sys);
      #1;
      tx_start = 1'b1;
      tx_data  = 8'h96;
      cs_wr    = 1'b1;
      cs_val   = 1'b0;
      @(posedge clk_sys);
      #1;
      tx_start = 1'b0;
      cs_wr    = 1'b0;
      chk("t5_cs_low", int'(spi_cs_n), 0);
      chk("t5_busy_up", int'(busy), 1);
      repeat (10) @(posedge clk_sys);
      #1;
      cs_wr  = 1'b1;
      cs_val = 1'b1;
      @(posedge clk_sys);
      #1 cs_wr = 1'b0;
      chk("t5_cs_high", int'(spi_cs_n), 1);
      chk("t5_still_busy", int'(busy), 1);
      wait_done(lat);
      chk("t5_rx", int'(rx_data), 8'h96);
      repeat (2) @(posedge clk_sys);

      // 6: reset mid-transfer after three SCK edges
      @(posedge clk_sys);
      #1;
      cs_wr  = 1'b1;
      cs_val = 1'b0;
      @(posedge clk_sys);
      #1 cs_wr = 1'b0;
      clr_counts();
      start(8'hF0);
      repeat (3 * D) @(posedge clk_sys);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_sck", int'(spi_sck), 0);
      chk("t6_mosi", int'(spi_mosi), 1);
      chk("t6_cs", int'(spi_cs_n), 1);
      chk("t6_busy", int'(busy), 0);
      chk("t6_rx", int'(rx_data), 8'hFF);
      chk("t6_done", int'(done), 0);
      repeat (2) @(posedge clk_sys);
      #1 reset_n = 1'b1;
      repeat (40) @(posedge clk_sys);
      #1;
      chk("t6_no_done", n_done, 0);
      chk("t6_sck_rises", n_rise, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_zc_spi_master
